// File: rtl/cpu_pkg.sv
// Shared MIPS pipeline definitions: instruction field positions, the NOP encoding
// and the IF/ID control states.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } if_id_state_t;

endpackage

// File: rtl/if_to_id_load_use_detect.sv
// Load-use hazard compare: the instruction in ID reads a register that the load
// currently in EX will write.
module load_use_detect (
    input  logic       id_valid,
    input  logic       mem_read,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // $zero is never a real dependency, so a load targeting r0 never stalls.
    assign hazard = id_valid & mem_read & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule

// File: rtl/if_to_id.sv
// IF/ID pipeline register with load-use stall and redirect squash control.
// Optional performance counters are built when IF_TO_ID_PERF_EN is defined.
//
// Handshake: if_valid qualifies instr_in in the cycle it is presented; IF must
// hold pc_in/instr_in steady while pc_write=0, and id_valid qualifies instr_out.
module if_to_id
    import cpu_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] instr_in,
    input  logic              if_valid,
    input  logic              idex_memRead,
    input  logic [4:0]        idex_rt,
    input  logic              redirect,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] instr_out,
    output logic              id_valid,
    output logic              pc_write,
    output logic              idex_bubble,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt,
    output if_id_state_t      state
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    if_id_state_t state_q;
    logic [2:0]   flush_ctr;
    logic         hazard;

    load_use_detect u_load_use_detect (
        .id_valid (id_valid),
        .mem_read (idex_memRead),
        .ex_rt    (idex_rt),
        .id_rs    (instr_out[RS_MSB:RS_LSB]),
        .id_rt    (instr_out[RT_MSB:RT_LSB]),
        .hazard   (hazard)
    );

    // Priority: reset > redirect > flush squash > hazard > normal advance.
    always_comb begin
        pc_write    = 1'b1;
        idex_bubble = 1'b0;
        if (!rst) begin
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
        end else if (redirect) begin
            pc_write    = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == FLUSH) begin
            pc_write    = 1'b1;
            idex_bubble = 1'b0;
        end else if (hazard) begin
            pc_write    = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            flush_ctr <= 3'd0;
            pc_out    <= '0;
            instr_out <= '0;
            id_valid  <= 1'b0;
        end else if (redirect) begin
            state_q   <= FLUSH;
            flush_ctr <= FLUSH_LOAD;
            instr_out <= DATA_W'(NOP_INSTR);
            id_valid  <= 1'b0;
        end else if (state_q == FLUSH) begin
            instr_out <= DATA_W'(NOP_INSTR);
            id_valid  <= 1'b0;
            flush_ctr <= (flush_ctr == 3'd0) ? 3'd0 : flush_ctr - 3'd1;
            if (flush_ctr <= 3'd1) begin
                state_q <= RUN;
            end
        end else if (hazard) begin
            // Hold ID contents; the load advances to MEM and ID/EX takes the bubble.
            state_q <= STALL;
        end else begin
            state_q   <= RUN;
            pc_out    <= pc_in;
            instr_out <= if_valid ? instr_in : DATA_W'(NOP_INSTR);
            id_valid  <= if_valid;
        end
    end

    assign state = state_q;

`ifdef IF_TO_ID_PERF_EN
    logic [PERF_W-1:0] stall_q;
    logic [PERF_W-1:0] flush_q;
    logic              stall_event;

    assign stall_event = rst & ~redirect & (state_q != FLUSH) & hazard;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_event && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (redirect && flush_q != '1) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_if_to_id.sv
// Self-checking bench for if_to_id: directed scenarios followed by random traffic,
// with a per-cycle expected-output queue built from a behavioural model.
module tb_if_to_id;
    import cpu_pkg::*;

    localparam int DATA_W = 32;
    localparam int FC     = 2;
    localparam int PERF_W = 4;
    localparam int SB_W   = 2 + 1 + 2 * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] pc_in, instr_in;
    logic              if_valid, idex_memRead, redirect;
    logic [4:0]        idex_rt;
    logic [DATA_W-1:0] pc_out, instr_out;
    logic              id_valid, pc_write, idex_bubble;
    logic [PERF_W-1:0] stall_cnt, flush_cnt;
    if_id_state_t      state;

    logic [SB_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [DATA_W-1:0] m_pc, m_instr;
    logic              m_valid;
    if_id_state_t      m_state;
    int                m_ctr;
    logic [PERF_W-1:0] m_stall, m_flush;

    if_to_id #(.DATA_W(DATA_W), .FLUSH_CYCLES(FC), .PERF_W(PERF_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .if_valid     (if_valid),
        .idex_memRead (idex_memRead),
        .idex_rt      (idex_rt),
        .redirect     (redirect),
        .pc_out       (pc_out),
        .instr_out    (instr_out),
        .id_valid     (id_valid),
        .pc_write     (pc_write),
        .idex_bubble  (idex_bubble),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .state        (state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // One clock: drive at negedge, check combinational controls, advance the model,
    // then compare registered outputs after the posedge.
    task automatic step(input logic r, input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] ins,
                        input logic v, input logic mr, input logic [4:0] rt, input logic rd);
        logic m_haz, e_pw, e_bub;
        logic [SB_W-1:0] e;
        @(negedge clk);
        rst = r; pc_in = pc; instr_in = ins; if_valid = v;
        idex_memRead = mr; idex_rt = rt; redirect = rd;
        #1;
        m_haz = m_valid && mr && (rt != 5'd0) &&
                (rt == m_instr[25:21] || rt == m_instr[20:16]);
        if (!r) begin
            e_pw = 1'b0; e_bub = 1'b1;
            m_pc = '0; m_instr = '0; m_valid = 1'b0; m_state = RUN; m_ctr = 0;
            m_stall = '0; m_flush = '0;
        end else if (rd) begin
            e_pw = 1'b1; e_bub = 1'b1;
            m_instr = '0; m_valid = 1'b0; m_state = FLUSH; m_ctr = FC;
`ifdef IF_TO_ID_PERF_EN
            m_flush = sat_inc(m_flush);
`endif
        end else if (m_state == FLUSH) begin
            e_pw = 1'b1; e_bub = 1'b0;
            m_instr = '0; m_valid = 1'b0; m_ctr = m_ctr - 1;
            if (m_ctr == 0) m_state = RUN;
        end else if (m_haz) begin
            e_pw = 1'b0; e_bub = 1'b1;
            m_state = STALL;
`ifdef IF_TO_ID_PERF_EN
            m_stall = sat_inc(m_stall);
`endif
        end else begin
            e_pw = 1'b1; e_bub = 1'b0;
            m_pc = pc; m_instr = v ? ins : '0; m_valid = v; m_state = RUN;
        end
        check("pc_write", 128'(pc_write), 128'(e_pw));
        check("idex_bubble", 128'(idex_bubble), 128'(e_bub));
        exp_q.push_back({2'(m_state), m_valid, m_instr, m_pc});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 128'(1), 128'(0));
        end else begin
            e = exp_q.pop_front();
            check("if_id_regs", 128'({2'(state), id_valid, instr_out, pc_out}), 128'(e));
        end
        check("stall_cnt", 128'(stall_cnt), 128'(m_stall));
        check("flush_cnt", 128'(flush_cnt), 128'(m_flush));
    endtask

    task automatic run(input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] ins,
                       input logic mr, input logic [4:0] rt, input logic rd);
        step(1'b1, pc, ins, 1'b1, mr, rt, rd);
    endtask

    initial begin
        logic [PERF_W-1:0] s0;
        logic [DATA_W-1:0] ri;
        m_pc = '0; m_instr = '0; m_valid = 1'b0; m_state = RUN; m_ctr = 0;
        m_stall = '0; m_flush = '0;

        // Reset holds two cycles, then the first fetch appears next cycle
        step(1'b0, 32'h4, 32'h8C01_0004, 1'b1, 1'b0, 5'd0, 1'b0);
        step(1'b0, 32'h4, 32'h8C01_0004, 1'b1, 1'b0, 5'd0, 1'b0);
        check("rst_id_valid", 128'(id_valid), 128'(0));
        check("rst_instr", 128'(instr_out), 128'(0));
        run(32'h8, 32'h8C01_0004, 1'b0, 5'd0, 1'b0);
        check("t1_instr", 128'(instr_out), 128'(32'h8C01_0004));

        // Load-use on rs: one stall cycle holding ID, then advance
        run(32'hC, 32'h0022_1820, 1'b0, 5'd0, 1'b0);
        run(32'h10, 32'h0002_1820, 1'b1, 5'd1, 1'b0);
        check("t2_held", 128'(instr_out), 128'(32'h0022_1820));
        run(32'h10, 32'h0002_1820, 1'b0, 5'd0, 1'b0);
        check("t2_adv", 128'(instr_out), 128'(32'h0002_1820));

        // rt=0 never stalls even when the field matches; unrelated rt does not stall
        run(32'h14, 32'h0064_2820, 1'b1, 5'd0, 1'b0);
        run(32'h18, 32'h0022_1820, 1'b1, 5'd7, 1'b0);
        // Hazard on rt field (add uses $2 as rt)
        run(32'h1C, 32'h0022_1820, 1'b1, 5'd2, 1'b0);
        run(32'h1C, 32'h0022_1820, 1'b0, 5'd0, 1'b0);

        // Redirect: 1+FC squashed slots, then the target is captured
        run(32'h20, 32'h0022_1820, 1'b0, 5'd0, 1'b1);
        for (int i = 0; i < FC; i++) run(32'h104 + 32'(4 * i), 32'h0022_1820, 1'b0, 5'd0, 1'b0);
        check("t4_squash", 128'(id_valid), 128'(0));
        run(32'h200, 32'h0043_2020, 1'b0, 5'd0, 1'b0);
        check("t4_target", 128'(instr_out), 128'(32'h0043_2020));

        // Redirect and hazard together: flush wins, no stall counted
        s0 = m_stall;
        run(32'h204, 32'h0043_2020, 1'b1, 5'd2, 1'b1);
        check("t5_state", 128'(state), 128'(FLUSH));
        check("t5_stall", 128'(stall_cnt), 128'(s0));
        for (int i = 0; i < FC; i++) run(32'h300, 32'h0022_1820, 1'b0, 5'd0, 1'b0);

        // Reset mid-flush aborts the squash
        run(32'h304, 32'h0022_1820, 1'b0, 5'd0, 1'b1);
        run(32'h308, 32'h0022_1820, 1'b0, 5'd0, 1'b0);
        step(1'b0, 32'h30C, 32'h0022_1820, 1'b1, 1'b0, 5'd0, 1'b0);
        run(32'h310, 32'h0022_1820, 1'b0, 5'd0, 1'b0);
        check("t6_valid", 128'(id_valid), 128'(1));

        // Twenty stalls to exercise counter saturation
        for (int i = 0; i < 20; i++) begin
            run(32'h400, 32'h0022_1820, 1'b1, 5'd1, 1'b0);
            run(32'h400, 32'h0022_1820, 1'b0, 5'd0, 1'b0);
        end
`ifdef IF_TO_ID_PERF_EN
        check("t6_sat", 128'(stall_cnt), 128'(4'hF));
`else
        check("t6_tied", 128'(stall_cnt), 128'(0));
`endif

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            ri = {6'h23, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            step(($urandom_range(0, 49) != 0), 32'($urandom), ri, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0));
        end

        check("sb_drained", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
